// File: rtl/ulpi_phy_responder_if.sv
// ULPI PHY-side bundle: link-driven STP/DATA and line inputs, PHY-driven DIR/NXT/DATA
// plus the Function/OTG Control register taps.
interface ulpi_phy_responder_if;
  logic       stp;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       dir;
  logic       nxt;
  logic [1:0] linestate;
  logic [1:0] vbus_state;
  logic [7:0] func_ctrl;
  logic [7:0] otg_ctrl;

  modport master (
    output stp, data_in, linestate, vbus_state,
    input  data_out, data_oe, dir, nxt, func_ctrl, otg_ctrl
  );

  modport slave (
    input  stp, data_in, linestate, vbus_state,
    output data_out, data_oe, dir, nxt, func_ctrl, otg_ctrl
  );
endinterface

// File: rtl/ulpi_phy_responder.sv
// USB3300-style ULPI PHY responder answering register read/write TX CMDs.
// Define ULPI_PHY_RXCMD_EN to emit RX CMD bytes on linestate/vbus_state changes.
module ulpi_phy_responder #(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0006
) (
  input logic               clk,
  input logic               rst,
  ulpi_phy_responder_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, WR_CMD, WR_DATA, WR_STP,
    RD_CMD, RD_TURN1, RD_DATA, RD_TURN2
`ifdef ULPI_PHY_RXCMD_EN
    , RX_TURN1, RX_DATA, RX_TURN2
`endif
  } state_t;

  state_t     state_q;
  logic [5:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] func_q, ifc_q, otg_q, scratch_q;
  logic       dir_q, nxt_q, oe_q;
  logic [7:0] dout_q;
  logic [7:0] rdata_d;

`ifdef ULPI_PHY_RXCMD_EN
  logic [3:0] line_q;
  logic       pending_q;
  logic       line_chg_d;
  assign line_chg_d = ({bus.vbus_state, bus.linestate} != line_q);
`else
  logic unused_line;
  assign unused_line = ^{bus.linestate, bus.vbus_state};
`endif

  // Base B writes, B+1 sets bits, B+2 clears bits; other addresses leave cur alone.
  function automatic logic [7:0] apply_wr(input logic [7:0] cur, input logic [5:0] base,
                                          input logic [5:0] a, input logic [7:0] d);
    if (a == base)              return d;
    else if (a == base + 6'd1)  return cur | d;
    else if (a == base + 6'd2)  return cur & ~d;
    else                        return cur;
  endfunction

  always_comb begin
    rdata_d = 8'h00;
    case (addr_q)
      6'h00:               rdata_d = VENDOR_ID[7:0];
      6'h01:               rdata_d = VENDOR_ID[15:8];
      6'h02:               rdata_d = PRODUCT_ID[7:0];
      6'h03:               rdata_d = PRODUCT_ID[15:8];
      6'h04, 6'h05, 6'h06: rdata_d = func_q;
      6'h07, 6'h08, 6'h09: rdata_d = ifc_q;
      6'h0A, 6'h0B, 6'h0C: rdata_d = otg_q;
      6'h16, 6'h17, 6'h18: rdata_d = scratch_q;
      default:             rdata_d = 8'h00;
    endcase
  end

  // Outputs are registered from the current state, so they trail the state by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 6'd0;
      wdata_q   <= 8'h00;
      func_q    <= 8'h41;
      ifc_q     <= 8'h00;
      otg_q     <= 8'h06;
      scratch_q <= 8'h00;
      dir_q     <= 1'b0;
      nxt_q     <= 1'b0;
      oe_q      <= 1'b0;
      dout_q    <= 8'h00;
`ifdef ULPI_PHY_RXCMD_EN
      line_q    <= 4'd0;
      pending_q <= 1'b0;
`endif
    end else begin
      dir_q  <= 1'b0;
      nxt_q  <= 1'b0;
      oe_q   <= 1'b0;
      dout_q <= 8'h00;
      case (state_q)
        IDLE: begin
          if (bus.data_in[7] && (bus.data_in[5:0] != 6'h2F)) begin
            addr_q  <= bus.data_in[5:0];
            state_q <= bus.data_in[6] ? RD_CMD : WR_CMD;
          end
`ifdef ULPI_PHY_RXCMD_EN
          else if (pending_q) begin
            state_q <= RX_TURN1;
          end
`endif
        end
        WR_CMD: begin
          nxt_q   <= 1'b1;
          state_q <= bus.stp ? IDLE : WR_DATA;
        end
        WR_DATA: begin
          nxt_q   <= 1'b1;
          wdata_q <= bus.data_in;
          state_q <= WR_STP;
        end
        WR_STP: begin
          if (bus.stp) begin
            func_q    <= apply_wr(func_q,    6'h04, addr_q, wdata_q);
            ifc_q     <= apply_wr(ifc_q,     6'h07, addr_q, wdata_q);
            otg_q     <= apply_wr(otg_q,     6'h0A, addr_q, wdata_q);
            scratch_q <= apply_wr(scratch_q, 6'h16, addr_q, wdata_q);
            state_q   <= IDLE;
          end
        end
        RD_CMD: begin
          nxt_q   <= 1'b1;
          state_q <= bus.stp ? IDLE : RD_TURN1;
        end
        RD_TURN1: begin
          dir_q   <= 1'b1;
          state_q <= RD_DATA;
        end
        RD_DATA: begin
          dir_q   <= 1'b1;
          oe_q    <= 1'b1;
          dout_q  <= rdata_d;
          state_q <= RD_TURN2;
        end
        RD_TURN2: state_q <= IDLE;
`ifdef ULPI_PHY_RXCMD_EN
        RX_TURN1: begin
          dir_q   <= 1'b1;
          state_q <= RX_DATA;
        end
        RX_DATA: begin
          dir_q     <= 1'b1;
          oe_q      <= 1'b1;
          dout_q    <= {4'b0000, bus.vbus_state, bus.linestate};
          pending_q <= 1'b0;
          state_q   <= RX_TURN2;
        end
        RX_TURN2: state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
`ifdef ULPI_PHY_RXCMD_EN
      // A change landing in the same cycle as RX_DATA re-arms the flag.
      line_q <= {bus.vbus_state, bus.linestate};
      if (line_chg_d) pending_q <= 1'b1;
`endif
    end
  end

  assign bus.dir       = dir_q;
  assign bus.nxt       = nxt_q;
  assign bus.data_oe   = oe_q;
  assign bus.data_out  = dout_q;
  assign bus.func_ctrl = func_q;
  assign bus.otg_ctrl  = otg_q;

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Bench for ulpi_phy_responder: table of register transactions plus hand sequences for
// abort, ignored commands, reset mid-read and RX CMD generation.
module tb_ulpi_phy_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ulpi_phy_responder_if bus();
  ulpi_phy_responder dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       is_wr;
    logic [7:0] cmd;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic [7:0] exp_func;
    logic [7:0] exp_otg;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int dir_cnt = 0;
  int oe_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, exp);
    end
  endtask

  // Advance one edge and sample outputs 1 ns later; driven bytes go to the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.dir === 1'b1) dir_cnt++;
    if (bus.data_oe === 1'b1) begin
      oe_cnt++;
      chk("oe_implies_dir", {7'd0, bus.dir}, 8'h01);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_drive actual=%02h required=none", bus.data_out);
      end else begin
        chk("bus_byte", bus.data_out, exp_q.pop_front());
      end
    end
    $display("cyc t=%0t dir=%b nxt=%b oe=%b dout=%02h", $time, bus.dir, bus.nxt, bus.data_oe, bus.data_out);
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [7:0] exp);
    bus.data_in = cmd;
    exp_q.push_back(exp);
    tick();
    bus.data_in = 8'h00;
    tick();
    chk("rd_nxt_n1", {7'd0, bus.nxt}, 8'h01);
    chk("rd_dir_n1", {7'd0, bus.dir}, 8'h00);
    tick();
    chk("rd_dir_n2", {6'd0, bus.dir, bus.data_oe}, 8'h02);
    tick();
    chk("rd_dir_n3", {6'd0, bus.dir, bus.data_oe}, 8'h03);
    tick();
    chk("rd_dir_n4", {6'd0, bus.dir, bus.data_oe}, 8'h00);
  endtask

  task automatic do_write(input logic [7:0] cmd, input logic [7:0] d, input logic [3:0] mid_line);
    bus.data_in = cmd;
    tick();
    tick();
    chk("wr_nxt_cmd", {7'd0, bus.nxt}, 8'h01);
    bus.data_in = d;
    tick();
    chk("wr_nxt_data", {7'd0, bus.nxt}, 8'h01);
    bus.data_in = 8'h00;
    {bus.vbus_state, bus.linestate} = mid_line;
    tick();
    chk("wr_nxt_stp", {7'd0, bus.nxt}, 8'h00);
    bus.stp = 1'b1;
    tick();
    bus.stp = 1'b0;
  endtask

  vec_t vecs[$];
  logic [7:0] ign_cmds[4];

  initial begin
    vecs = '{
      '{1'b0, 8'hC4, 8'h00, 8'h41, 8'h41, 8'h06},
      '{1'b0, 8'hC0, 8'h00, 8'h24, 8'h41, 8'h06},
      '{1'b0, 8'hC1, 8'h00, 8'h04, 8'h41, 8'h06},
      '{1'b0, 8'hC2, 8'h00, 8'h06, 8'h41, 8'h06},
      '{1'b0, 8'hC3, 8'h00, 8'h00, 8'h41, 8'h06},
      '{1'b0, 8'hCA, 8'h00, 8'h06, 8'h41, 8'h06},
      '{1'b0, 8'hD6, 8'h00, 8'h00, 8'h41, 8'h06},
      '{1'b1, 8'h8A, 8'h55, 8'h00, 8'h41, 8'h55},
      '{1'b1, 8'h8B, 8'h02, 8'h00, 8'h41, 8'h57},
      '{1'b1, 8'h8C, 8'h50, 8'h00, 8'h41, 8'h07},
      '{1'b0, 8'hCB, 8'h00, 8'h07, 8'h41, 8'h07},
      '{1'b0, 8'hCC, 8'h00, 8'h07, 8'h41, 8'h07},
      '{1'b1, 8'h80, 8'hFF, 8'h00, 8'h41, 8'h07},
      '{1'b0, 8'hC0, 8'h00, 8'h24, 8'h41, 8'h07},
      '{1'b1, 8'hBE, 8'h33, 8'h00, 8'h41, 8'h07},
      '{1'b0, 8'hFE, 8'h00, 8'h00, 8'h41, 8'h07},
      '{1'b1, 8'h96, 8'h5A, 8'h00, 8'h41, 8'h07},
      '{1'b1, 8'h98, 8'h0F, 8'h00, 8'h41, 8'h07},
      '{1'b0, 8'hD7, 8'h00, 8'h50, 8'h41, 8'h07},
      '{1'b1, 8'h85, 8'h80, 8'h00, 8'hC1, 8'h07},
      '{1'b1, 8'h86, 8'h41, 8'h00, 8'h80, 8'h07},
      '{1'b0, 8'hC4, 8'h00, 8'h80, 8'h80, 8'h07},
      '{1'b1, 8'h87, 8'h0F, 8'h00, 8'h80, 8'h07},
      '{1'b0, 8'hC9, 8'h00, 8'h0F, 8'h80, 8'h07}
    };
    ign_cmds[0] = 8'hEF;
    ign_cmds[1] = 8'h40;
    ign_cmds[2] = 8'hAF;
    ign_cmds[3] = 8'h2F;

    rst = 1'b1;
    bus.stp = 1'b0;
    bus.data_in = 8'h00;
    bus.linestate = 2'b00;
    bus.vbus_state = 2'b00;
    repeat (3) tick();
    chk("rst_outputs", {5'd0, bus.dir, bus.nxt, bus.data_oe}, 8'h00);
    chk("rst_dout", bus.data_out, 8'h00);
    chk("rst_func", bus.func_ctrl, 8'h41);
    chk("rst_otg", bus.otg_ctrl, 8'h06);
    rst = 1'b0;
    tick();

    // Abort a scratch write with stp during WR_CMD.
    bus.data_in = 8'h96;
    tick();
    bus.data_in = 8'h00;
    bus.stp = 1'b1;
    tick();
    chk("abort_nxt_cmd", {7'd0, bus.nxt}, 8'h01);
    bus.stp = 1'b0;
    tick();
    chk("abort_nxt_idle", {7'd0, bus.nxt}, 8'h00);
    tick();
    chk("abort_nxt_idle2", {6'd0, bus.dir, bus.nxt}, 8'h00);

    foreach (ign_cmds[i]) begin
      bus.data_in = ign_cmds[i];
      tick();
      bus.data_in = 8'h00;
      tick();
      chk("ignored_cmd_nxt", {6'd0, bus.dir, bus.nxt}, 8'h00);
      tick();
      chk("ignored_cmd_nxt2", {6'd0, bus.dir, bus.nxt}, 8'h00);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].cmd, vecs[i].wdata, 4'b0000);
        chk("wr_func", bus.func_ctrl, vecs[i].exp_func);
        chk("wr_otg", bus.otg_ctrl, vecs[i].exp_otg);
      end else begin
        do_read(vecs[i].cmd, vecs[i].exp_rd);
      end
    end

    // Reset while in RD_DATA: bus released on that edge, partial state discarded.
    bus.data_in = 8'hC4;
    tick();
    bus.data_in = 8'h00;
    tick();
    tick();
    chk("mid_rst_dir_before", {7'd0, bus.dir}, 8'h01);
    rst = 1'b1;
    tick();
    chk("mid_rst_bus", {6'd0, bus.dir, bus.data_oe}, 8'h00);
    chk("mid_rst_func", bus.func_ctrl, 8'h41);
    rst = 1'b0;
    tick();
    do_read(8'hD6, 8'h00);

`ifdef ULPI_PHY_RXCMD_EN
    begin
      int d0, o0;
      d0 = dir_cnt;
      o0 = oe_cnt;
      bus.linestate = 2'b01;
      exp_q.push_back(8'h01);
      repeat (8) tick();
      chk("rx_dir_cycles", 8'(dir_cnt - d0), 8'd2);
      chk("rx_oe_cycles", 8'(oe_cnt - o0), 8'd1);

      // Two changes across a write collapse into one RX CMD, deferred behind a read.
      o0 = oe_cnt;
      bus.linestate = 2'b10;
      do_write(8'h96, 8'h3C, 4'b1011);
      chk("rx_wr_scratch_otg", bus.otg_ctrl, 8'h06);
      do_read(8'hD6, 8'h3C);
      exp_q.push_back(8'h0B);
      repeat (10) tick();
      chk("rx_collapsed_count", 8'(oe_cnt - o0), 8'd2);
    end
`else
    begin
      int d0;
      d0 = dir_cnt;
      for (int i = 0; i < 6; i++) begin
        bus.linestate = 2'(i);
        bus.vbus_state = 2'(i + 1);
        tick();
      end
      repeat (6) tick();
      chk("no_rx_dir", 8'(dir_cnt - d0), 8'd0);
    end
`endif

    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
